// File: rtl/if_axi_prefetch_if.sv
// AXI read-only bus bundle between the instruction prefetcher and its memory slave.
// Only AR and R channels exist; the fetch path never writes.
interface if_axi_prefetch_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              arvalid_if;
    logic              arready_if;
    logic [3:0]        arid_if;
    logic [ADDR_W-1:0] araddr_if;
    logic [7:0]        arlen_if;
    logic [2:0]        arsize_if;
    logic [1:0]        arburst_if;

    logic              rvalid_if;
    logic              rready_if;
    logic [DATA_W-1:0] rdata_if;
    logic [1:0]        rresp_if;
    logic              rlast_if;
    logic [3:0]        rid_if;

    modport master (
        output arvalid_if, arid_if, araddr_if, arlen_if, arsize_if, arburst_if,
        input  arready_if,
        input  rvalid_if, rdata_if, rresp_if, rlast_if, rid_if,
        output rready_if
    );

    modport slave (
        input  arvalid_if, arid_if, araddr_if, arlen_if, arsize_if, arburst_if,
        output arready_if,
        output rvalid_if, rdata_if, rresp_if, rlast_if, rid_if,
        input  rready_if
    );
endinterface

// File: rtl/if_axi_prefetch.sv
// Instruction prefetcher: issues aligned AXI INCR read bursts, splits beats into 32-bit
// instructions and queues them in a FIFO for the core. Redirect flushes and restarts fetch.
module if_axi_prefetch #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [63:0] BASE_PC    = 64'h8000_0000,
    parameter logic [3:0]  AXI_ID_IF  = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_err,
    output logic              stall_if,
    output logic              axi_idle_if,
    if_axi_prefetch_if.master axi
);
    localparam int unsigned LANES       = DATA_W / 32;
    localparam int unsigned BEAT_BYTES  = DATA_W / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned BURST_INSNS = BURST_LEN * LANES;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  AR_SIZE     = 3'($clog2(BEAT_BYTES));
    localparam logic [ADDR_W-1:0] BURST_MASK = ~ADDR_W'(BURST_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    typedef struct packed {
        logic              err;
        logic [ADDR_W-1:0] pc;
        logic [31:0]       insn;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
    logic              abort_q, abort_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];

    logic              ar_fire;
    logic              beat_fire;
    logic              credit_ok;
    logic              do_push;
    logic              pop;
    logic [PTR_W:0]    free_cnt;
    logic [PTR_W:0]    n_push;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] lane_pc;
    entry_t            head;

    // AR fields are constant except the address, which is held in araddr_q for the whole ADDR phase
    assign axi.arvalid_if = (state_q == StAddr);
    assign axi.arid_if    = AXI_ID_IF;
    assign axi.araddr_if  = araddr_q;
    assign axi.arlen_if   = 8'(BURST_LEN - 1);
    assign axi.arsize_if  = AR_SIZE;
    assign axi.arburst_if = 2'b01;
    assign axi.rready_if  = (state_q == StData) || (state_q == StDrain);

    assign ar_fire   = (state_q == StAddr) && axi.arready_if;
    assign beat_fire = axi.rready_if && axi.rvalid_if;
    assign free_cnt  = (PTR_W + 1)'(FIFO_DEPTH) - count_q;
    // A whole burst must fit before it is requested, so R never has to stall
    assign credit_ok = free_cnt >= (PTR_W + 1)'(BURST_INSNS);

    // Fetch FSM: burst sequencing, fetch address tracking and redirect handling
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        araddr_d     = araddr_q;
        beat_addr_d  = beat_addr_q;
        abort_d      = abort_q;
        do_push      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    fetch_addr_d = redirect_pc;
                end else if (credit_ok) begin
                    state_d  = StAddr;
                    araddr_d = fetch_addr_q & BURST_MASK;
                    abort_d  = 1'b0;
                end
            end
            StAddr: begin
                // AR must complete even if redirected; remember to discard its data
                if (redirect) begin
                    fetch_addr_d = redirect_pc;
                    abort_d      = 1'b1;
                end
                if (ar_fire) begin
                    beat_addr_d = araddr_q;
                    state_d     = (redirect || abort_q) ? StDrain : StData;
                end
            end
            StData: begin
                if (redirect) begin
                    fetch_addr_d = redirect_pc;
                    state_d      = (beat_fire && axi.rlast_if) ? StIdle : StDrain;
                end else if (beat_fire) begin
                    do_push     = 1'b1;
                    beat_addr_d = beat_addr_q + ADDR_W'(BEAT_BYTES);
                    if (axi.rlast_if) begin
                        state_d      = StIdle;
                        fetch_addr_d = araddr_q + ADDR_W'(BURST_BYTES);
                    end
                end
            end
            StDrain: begin
                if (redirect) begin
                    fetch_addr_d = redirect_pc;
                end
                if (beat_fire && axi.rlast_if) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO next state: multi-lane push of one beat, single pop, redirect flush wins
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        n_push   = '0;
        wr_idx   = '0;
        lane_pc  = '0;
        pop      = instr_valid && instr_ready;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    lane_pc = beat_addr_q + ADDR_W'(4 * k);
                    // Lanes before the fetch target belong to the aligned prefix of the burst
                    if (lane_pc >= fetch_addr_q) begin
                        wr_idx        = wr_ptr_q + n_push[PTR_W-1:0];
                        mem_d[wr_idx] = '{err:  (axi.rresp_if != 2'b00),
                                          pc:   lane_pc,
                                          insn: axi.rdata_if[32*k +: 32]};
                        n_push        = n_push + (PTR_W + 1)'(1);
                    end
                end
            end
            wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + n_push - (PTR_W + 1)'(pop);
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_addr_q <= BASE_PC[ADDR_W-1:0];
            araddr_q     <= '0;
            beat_addr_q  <= '0;
            abort_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            araddr_q     <= araddr_d;
            beat_addr_q  <= beat_addr_d;
            abort_q      <= abort_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; validity is tracked by count_q so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? head.insn : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign instr_err   = instr_valid ? head.err : 1'b0;
    assign stall_if    = !instr_valid;
    assign axi_idle_if = (state_q == StIdle);
endmodule

// File: tb/tb_if_axi_prefetch.sv
// Directed bench for if_axi_prefetch: AXI read slave model, core-side monitor and
// hand-derived expected PC streams for reset, redirect, drain, backpressure and error cases.
module tb_if_axi_prefetch;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_err;
    logic        stall_if;
    logic        axi_idle_if;

    always #5 clk = ~clk;

    if_axi_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    if_axi_prefetch #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .FIFO_DEPTH(16),
        .BASE_PC   (64'h8000_0000),
        .AXI_ID_IF (4'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_err  (instr_err),
        .stall_if   (stall_if),
        .axi_idle_if(axi_idle_if),
        .axi        (axi)
    );

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
        logic        err;
    } rec_t;

    rec_t        rec[$];
    logic [63:0] ar_log[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          ar_delay = 0;
    logic [63:0] err_addr = '1;
    logic [63:0] s_addr = '0;
    int          s_beat = 0;
    bit          s_busy = 1'b0;
    int          s_wait = 0;

    // Memory contents as a function of address
    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return {pc[15:0] ^ 16'h5A5A, pc[15:0]};
    endfunction

    function automatic logic [63:0] ar_at(input int i);
        return (ar_log.size() > i) ? ar_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_recs(input int n, input int budget, input string tag);
        int c = 0;
        while (rec.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check_eq(tag, 64'(rec.size() >= n), 64'd1);
    endtask

    task automatic check_stream(input string tag, input logic [63:0] start, input int n);
        logic [63:0] pc;
        check_eq($sformatf("%s_len", tag), 64'(rec.size() >= n), 64'd1);
        for (int i = 0; i < n && i < rec.size(); i++) begin
            pc = start + 64'(4 * i);
            check_eq($sformatf("%s_pc%0d", tag, i), rec[i].pc, pc);
            check_eq($sformatf("%s_insn%0d", tag, i), 64'(rec[i].insn), 64'(mem_word(pc)));
            check_eq($sformatf("%s_err%0d", tag, i), 64'(rec[i].err),
                     64'((pc & ~64'h7) == err_addr));
        end
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rec.delete();
        ar_log.delete();
    endtask

    // Core-side monitor: record every instruction the core actually consumes
    always @(negedge clk) begin
        if (rst_n && !redirect && instr_valid && instr_ready) begin
            rec.push_back('{insn: instr, pc: instr_pc, err: instr_err});
        end
    end

    // AXI read slave: configurable AR delay, zero-wait R beats, SLVERR on err_addr beat
    initial begin
        bit          arf;
        bit          rf;
        logic [63:0] ar_a;
        logic [63:0] beat_a;
        axi.arready_if = 1'b0;
        axi.rvalid_if  = 1'b0;
        axi.rdata_if   = '0;
        axi.rresp_if   = 2'b00;
        axi.rlast_if   = 1'b0;
        axi.rid_if     = 4'h0;
        forever begin
            @(negedge clk);
            arf  = axi.arvalid_if && axi.arready_if;
            rf   = axi.rvalid_if && axi.rready_if;
            ar_a = axi.araddr_if;
            if (arf && rst_n) ar_log.push_back(ar_a);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_busy = 1'b0;
                s_beat = 0;
                s_wait = 0;
            end else begin
                if (rf) begin
                    s_beat++;
                    if (s_beat == BL) begin
                        s_busy = 1'b0;
                        s_beat = 0;
                    end
                end
                if (arf) begin
                    s_addr = ar_a;
                    s_busy = 1'b1;
                    s_beat = 0;
                end
            end
            if (rst_n && !s_busy && axi.arvalid_if) begin
                axi.arready_if = (s_wait >= ar_delay);
                s_wait++;
            end else begin
                axi.arready_if = 1'b0;
                s_wait         = 0;
            end
            beat_a        = s_addr + 64'(8 * s_beat);
            axi.rvalid_if = s_busy;
            axi.rdata_if  = {mem_word(beat_a + 64'd4), mem_word(beat_a)};
            axi.rlast_if  = s_busy && (s_beat == BL - 1);
            axi.rresp_if  = (beat_a == err_addr) ? 2'b10 : 2'b00;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arvalid", 64'(axi.arvalid_if), 64'd0);
        check_eq("rst_rready", 64'(axi.rready_if), 64'd0);
        check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_instr", 64'(instr), 64'd0);
        check_eq("rst_instr_pc", instr_pc, 64'd0);
        check_eq("rst_instr_err", 64'(instr_err), 64'd0);
        check_eq("rst_stall", 64'(stall_if), 64'd1);
        check_eq("rst_idle", 64'(axi_idle_if), 64'd1);
        check_eq("arlen", 64'(axi.arlen_if), 64'd3);
        check_eq("arsize", 64'(axi.arsize_if), 64'd3);
        check_eq("arburst", 64'(axi.arburst_if), 64'd1);
        check_eq("arid", 64'(axi.arid_if), 64'd0);

        // Reset release streams from BASE_PC
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        wait_recs(8, 200, "t1_timeout");
        check_eq("t1_araddr", ar_at(0), 64'h8000_0000);
        check_stream("t1", 64'h8000_0000, 8);

        // Redirect from IDLE into the middle of a burst; check latency and lane discard
        instr_ready = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check_eq("t2_idle_full", 64'(axi_idle_if), 64'd1);
        do_redirect(64'h8000_0014);
        @(negedge clk);
        check_eq("t2_n1_arvalid", 64'(axi.arvalid_if), 64'd0);
        check_eq("t2_flush", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check_eq("t2_n2_arvalid", 64'(axi.arvalid_if), 64'd1);
        check_eq("t2_araddr", axi.araddr_if, 64'h8000_0000);
        repeat (3) @(negedge clk);
        check_eq("t2_discard_valid", 64'(instr_valid), 64'd0);
        check_eq("t2_discard_stall", 64'(stall_if), 64'd1);
        @(negedge clk);
        check_eq("t2_first_valid", 64'(instr_valid), 64'd1);
        check_eq("t2_first_pc", instr_pc, 64'h8000_0014);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_recs(8, 200, "t2_timeout");
        check_eq("t2_ar0", ar_at(0), 64'h8000_0000);
        check_stream("t2", 64'h8000_0014, 8);

        // SLVERR on beat 1 of the burst
        err_addr = 64'h8000_1008;
        do_redirect(64'h8000_1000);
        wait_recs(8, 200, "t3_timeout");
        check_stream("t3", 64'h8000_1000, 8);

        // Redirect while beat 2 of 4 is on the bus
        do_redirect(64'h8000_2000);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #2;
            found = s_busy && (s_addr == 64'h8000_2000) && (s_beat == 2) && axi.rvalid_if;
        end
        check_eq("t4_found_beat2", 64'(found), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h8000_3000;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rec.delete();
        ar_log.delete();
        @(negedge clk);
        check_eq("t4_flush", 64'(instr_valid), 64'd0);
        check_eq("t4_drain_busy", 64'(axi_idle_if), 64'd0);
        check_eq("t4_drain_rready", 64'(axi.rready_if), 64'd1);
        wait_recs(8, 200, "t4_timeout");
        check_eq("t4_ar0", ar_at(0), 64'h8000_3000);
        check_stream("t4", 64'h8000_3000, 8);

        // Backpressure: FIFO fills, fetching stops, nothing lost on release
        instr_ready = 1'b0;
        do_redirect(64'h8000_4000);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_eq("t5_ar_count", 64'(ar_log.size()), 64'd2);
        check_eq("t5_idle", 64'(axi_idle_if), 64'd1);
        check_eq("t5_head_pc", instr_pc, 64'h8000_4000);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_recs(24, 300, "t5_timeout");
        check_stream("t5", 64'h8000_4000, 24);

        // Slow AR with redirect in the second ADDR cycle; burst must be drained
        ar_delay    = 5;
        instr_ready = 1'b0;
        do_redirect(64'h8000_5000);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #2;
            found = axi.arvalid_if && (axi.araddr_if == 64'h8000_5000);
        end
        check_eq("t6_found_ar", 64'(found), 64'd1);
        ar_log.delete();
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_6000;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rec.delete();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6_hold%0d", c), axi.araddr_if, 64'h8000_5000);
            found = axi.arvalid_if && axi.arready_if;
        end
        check_eq("t6_handshake", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_recs(8, 300, "t6_timeout");
        check_eq("t6_ar0", ar_at(0), 64'h8000_5000);
        check_eq("t6_ar1", ar_at(1), 64'h8000_6000);
        check_stream("t6", 64'h8000_6000, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/if_axi_prefetch.md
IF_AXI_PREFETCH -- requirements
Module: if_axi_prefetch

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 64, address width; DATA_W, 64, AXI read data width (64 or 128); BURST_LEN, 4, beats per AXI burst (1,2,4,8); FIFO_DEPTH, 16, instruction FIFO entries (power of 2, at least BURST_LEN*DATA_W/32); BASE_PC, 64'h8000_0000, reset fetch address.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low. Ports: clk, in, 1, clock; rst_n, in, 1, synchronous active-low reset.
REQ-003 Core ports: redirect, in, 1, flush and restart fetch; redirect_pc, in, ADDR_W, new fetch PC (4-byte aligned); instr_valid, out, 1, FIFO head valid; instr_ready, in, 1, core consumes head; instr, out, 32, head instruction; instr_pc, out, ADDR_W, head PC; instr_err, out, 1, head fetched with non-OKAY rresp; stall_if, out, 1, equals !instr_valid; axi_idle_if, out, 1, FSM in IDLE.
REQ-004 AXI AR ports: arvalid_if, out, 1; arready_if, in, 1; arid_if, out, 4, constant AXI_ID_IF; araddr_if, out, ADDR_W; arlen_if, out, 8, BURST_LEN-1; arsize_if, out, 3, log2(DATA_W/8); arburst_if, out, 2, INCR.
REQ-005 AXI R ports: rvalid_if, in, 1; rready_if, out, 1; rdata_if, in, DATA_W; rresp_if, in, 2; rlast_if, in, 1; rid_if, in, 4 (ignored). The block issues no writes; write channels are not present.

Function
REQ-006 FSM states: IDLE, ADDR, DATA, DRAIN. One burst outstanding at most.
REQ-007 IDLE->ADDR when FIFO free entries >= BURST_LEN*DATA_W/32 and no redirect this cycle.
REQ-008 ADDR: arvalid_if=1, araddr_if = fetch_addr with low log2(BURST_LEN*DATA_W/8) bits cleared; araddr_if and all AR fields stable until arready_if. ADDR->DATA on arvalid_if&&arready_if.
REQ-009 DATA: rready_if=1; each accepted beat splits into DATA_W/32 instructions, lane k = rdata_if[32k+31:32k], PC = beat address + 4k; lanes with PC < fetch_addr are discarded, remainder pushed in ascending PC order within one cycle.
REQ-010 DATA->IDLE on accepted beat with rlast_if=1; fetch_addr advances to burst base + BURST_LEN*DATA_W/8 (wraps modulo 2^ADDR_W).
REQ-011 rresp_if != OKAY: affected instructions pushed with err=1; fetch continues.
REQ-012 FIFO: push and pop same cycle allowed when not empty; pop when instr_valid&&instr_ready; outputs are registered FIFO head, 0 when empty.
REQ-013 Credit in REQ-007 guarantees no overflow; rready_if is never deasserted mid-burst in DATA.
REQ-014 redirect (priority over push/pop): FIFO empty next cycle; fetch_addr <= redirect_pc; IDLE stays IDLE; ADDR keeps arvalid_if and AR fields until handshake, then DRAIN; DATA->DRAIN unless this beat has rlast_if (then IDLE).
REQ-015 DRAIN: rready_if=1, beats discarded, no pushes; DRAIN->IDLE on accepted rlast_if. Redirect in DRAIN only updates fetch_addr.
REQ-016 Latency: redirect in cycle N, zero-wait slave -> arvalid_if in N+2, first instr_valid one cycle after first accepted beat.

Reset
REQ-017 While !rst_n at clk edge: FSM=IDLE, fetch_addr=BASE_PC, FIFO empty; arvalid_if=0, rready_if=0, instr_valid=0, instr=0, instr_pc=0, instr_err=0, stall_if=1, axi_idle_if=1.
REQ-018 Reset mid-burst abandons the transaction; the environment resets the slave with the same rst_n.

Verification
REQ-019 Reset release, DATA_W=64, BURST_LEN=4, instr_ready=1 -> araddr 0x8000_0000, arlen 3, arsize 3; 8 instructions out with PCs 0x8000_0000..0x8000_001C in order.
REQ-020 redirect_pc=0x8000_0014 from IDLE -> araddr 0x8000_0000; first instr_pc 0x8000_0014, lanes below discarded.
REQ-021 redirect on beat 2 of 4 -> FIFO empties, remaining beats drained, next araddr from redirect_pc, no stale instruction reaches core.
REQ-022 instr_ready=0 held -> FIFO fills to FIFO_DEPTH, no further AR issued, no lost or duplicated instruction on release.
REQ-023 rresp=SLVERR on beat 1 -> its 2 instructions have instr_err=1, others 0.
REQ-024 arready_if delayed 5 cycles with redirect in cycle 2 -> araddr stable until handshake, burst then fully drained.
